// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction fetch / data) to one-slave Wishbone arbiter.
// Grant is held for the whole bus cycle; a watchdog errors out hung slave accesses.
module wb_bus_arbiter #(
    parameter bit          DATA_PRIORITY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] iwb_adr_i,
    output logic [31:0] iwb_dat_o,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,

    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] dwb_dat_o,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,

    output logic [31:0] mwb_adr_o,
    output logic [31:0] mwb_dat_o,
    input  logic [31:0] mwb_dat_i,
    output logic        mwb_we_o,
    output logic [3:0]  mwb_sel_o,
    output logic        mwb_cyc_o,
    output logic        mwb_stb_o,
    input  logic        mwb_ack_i,
    input  logic        mwb_err_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam int              WDOG_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: data port held the bus last
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                i_req, d_req, expire;

    assign i_req  = iwb_cyc_i & iwb_stb_i;
    assign d_req  = dwb_cyc_i & dwb_stb_i;
    assign expire = WDOG_EN && (state_q != IDLE) && (wdog_q == WDOG_MAX);

    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req)
                    state_d = (DATA_PRIORITY || !last_d_q) ? GNT_D : GNT_I;
                else if (d_req)
                    state_d = GNT_D;
                else if (i_req)
                    state_d = GNT_I;
            end
            GNT_I: begin
                if (expire) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else if (!iwb_cyc_i) begin
                    last_d_d = 1'b0;
                    state_d  = d_req ? GNT_D : (i_req ? GNT_I : IDLE);
                end
            end
            GNT_D: begin
                if (expire) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else if (!dwb_cyc_i) begin
                    last_d_d = 1'b1;
                    state_d  = i_req ? GNT_I : (d_req ? GNT_D : IDLE);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on any response or ownership change, so it only measures one stalled beat.
    always_comb begin
        wdog_d = wdog_q;
        if (!WDOG_EN || expire || (state_d != state_q) || mwb_ack_i || mwb_err_i)
            wdog_d = '0;
        else if ((state_q != IDLE) && mwb_stb_o)
            wdog_d = wdog_q + 1'b1;
    end

    always_comb begin
        mwb_adr_o = '0;
        mwb_dat_o = '0;
        mwb_we_o  = 1'b0;
        mwb_sel_o = 4'h0;
        mwb_cyc_o = 1'b0;
        mwb_stb_o = 1'b0;
        iwb_ack_o = 1'b0;
        iwb_err_o = 1'b0;
        dwb_ack_o = 1'b0;
        dwb_err_o = 1'b0;
        grant_o   = 2'b00;
        unique case (state_q)
            GNT_I: begin
                grant_o   = 2'b01;
                mwb_adr_o = iwb_adr_i;
                mwb_sel_o = 4'hF;
                mwb_cyc_o = iwb_cyc_i & ~expire;
                mwb_stb_o = iwb_stb_i & ~expire;
                iwb_err_o = mwb_err_i | expire;
                iwb_ack_o = mwb_ack_i & ~mwb_err_i & ~expire;
            end
            GNT_D: begin
                grant_o   = 2'b10;
                mwb_adr_o = dwb_adr_i;
                mwb_dat_o = dwb_dat_i;
                mwb_we_o  = dwb_we_i;
                mwb_sel_o = dwb_sel_i;
                mwb_cyc_o = dwb_cyc_i & ~expire;
                mwb_stb_o = dwb_stb_i & ~expire;
                dwb_err_o = mwb_err_i | expire;
                dwb_ack_o = mwb_ack_i & ~mwb_err_i & ~expire;
            end
            default: ;
        endcase
    end

    assign iwb_dat_o = mwb_dat_i;
    assign dwb_dat_o = mwb_dat_i;
    assign timeout_o = expire;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench: instance a (data priority, 4-cycle watchdog) and instance b
// (round-robin, watchdog off) share all inputs.
module tb_wb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iwb_adr, dwb_adr, dwb_dat, mwb_dat_in;
    logic        iwb_cyc, iwb_stb, dwb_we, dwb_cyc, dwb_stb, mwb_ack, mwb_err;
    logic [3:0]  dwb_sel;

    logic [31:0] a_iwb_dat, a_dwb_dat, a_mwb_adr, a_mwb_dat;
    logic        a_iwb_ack, a_iwb_err, a_dwb_ack, a_dwb_err;
    logic        a_mwb_we, a_mwb_cyc, a_mwb_stb, a_timeout;
    logic [3:0]  a_mwb_sel;
    logic [1:0]  a_grant;

    logic [31:0] b_iwb_dat, b_dwb_dat, b_mwb_adr, b_mwb_dat;
    logic        b_iwb_ack, b_iwb_err, b_dwb_ack, b_dwb_err;
    logic        b_mwb_we, b_mwb_cyc, b_mwb_stb, b_timeout;
    logic [3:0]  b_mwb_sel;
    logic [1:0]  b_grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.DATA_PRIORITY(1'b1), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr), .iwb_dat_o(a_iwb_dat), .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb),
        .iwb_ack_o(a_iwb_ack), .iwb_err_o(a_iwb_err),
        .dwb_adr_i(dwb_adr), .dwb_dat_i(dwb_dat), .dwb_dat_o(a_dwb_dat), .dwb_we_i(dwb_we),
        .dwb_sel_i(dwb_sel), .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb),
        .dwb_ack_o(a_dwb_ack), .dwb_err_o(a_dwb_err),
        .mwb_adr_o(a_mwb_adr), .mwb_dat_o(a_mwb_dat), .mwb_dat_i(mwb_dat_in), .mwb_we_o(a_mwb_we),
        .mwb_sel_o(a_mwb_sel), .mwb_cyc_o(a_mwb_cyc), .mwb_stb_o(a_mwb_stb),
        .mwb_ack_i(mwb_ack), .mwb_err_i(mwb_err),
        .grant_o(a_grant), .timeout_o(a_timeout)
    );

    wb_bus_arbiter #(.DATA_PRIORITY(1'b0), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .iwb_adr_i(iwb_adr), .iwb_dat_o(b_iwb_dat), .iwb_cyc_i(iwb_cyc), .iwb_stb_i(iwb_stb),
        .iwb_ack_o(b_iwb_ack), .iwb_err_o(b_iwb_err),
        .dwb_adr_i(dwb_adr), .dwb_dat_i(dwb_dat), .dwb_dat_o(b_dwb_dat), .dwb_we_i(dwb_we),
        .dwb_sel_i(dwb_sel), .dwb_cyc_i(dwb_cyc), .dwb_stb_i(dwb_stb),
        .dwb_ack_o(b_dwb_ack), .dwb_err_o(b_dwb_err),
        .mwb_adr_o(b_mwb_adr), .mwb_dat_o(b_mwb_dat), .mwb_dat_i(mwb_dat_in), .mwb_we_o(b_mwb_we),
        .mwb_sel_o(b_mwb_sel), .mwb_cyc_o(b_mwb_cyc), .mwb_stb_o(b_mwb_stb),
        .mwb_ack_i(mwb_ack), .mwb_err_i(mwb_err),
        .grant_o(b_grant), .timeout_o(b_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic idle_inputs();
        iwb_adr = '0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
        dwb_adr = '0; dwb_dat = '0; dwb_we = 1'b0; dwb_sel = 4'h0;
        dwb_cyc = 1'b0; dwb_stb = 1'b0;
        mwb_dat_in = '0; mwb_ack = 1'b0; mwb_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit exp_d;

        // Reset holds everything low even with requests and a stray ack present.
        rst_n = 1'b0;
        idle_inputs();
        iwb_cyc = 1'b1; iwb_stb = 1'b1; dwb_cyc = 1'b1; dwb_stb = 1'b1; mwb_ack = 1'b1;
        tick(); tick(); smp();
        check("rst_grant",   32'(a_grant),   32'd0);
        check("rst_cyc",     32'(a_mwb_cyc), 32'd0);
        check("rst_iack",    32'(a_iwb_ack), 32'd0);
        check("rst_dack",    32'(a_dwb_ack), 32'd0);
        check("rst_timeout", 32'(a_timeout), 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        tick(); smp();
        check("idle_grant", 32'(a_grant),   32'd0);
        check("idle_cyc",   32'(a_mwb_cyc), 32'd0);
        check("idle_adr",   a_mwb_adr,      32'd0);

        // Single fetch, slave answers two cycles after the request.
        iwb_adr = 32'h0000_0100; iwb_cyc = 1'b1; iwb_stb = 1'b1;
        smp();
        check("fetch_latency", 32'(a_mwb_cyc), 32'd0);
        tick(); smp();
        check("fetch_grant", 32'(a_grant),   32'd1);
        check("fetch_adr",   a_mwb_adr,      32'h0000_0100);
        check("fetch_sel",   32'(a_mwb_sel), 32'hF);
        check("fetch_we",    32'(a_mwb_we),  32'd0);
        tick();
        mwb_ack = 1'b1; mwb_dat_in = 32'hDEAD_BEEF;
        smp();
        check("fetch_iack", 32'(a_iwb_ack), 32'd1);
        check("fetch_idat", a_iwb_dat,      32'hDEAD_BEEF);
        check("fetch_dack", 32'(a_dwb_ack), 32'd0);
        tick();
        mwb_ack = 1'b0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick(); smp();
        check("fetch_release", 32'(a_grant), 32'd0);

        // Contention: data wins on a; b last served instr, so data wins there too.
        iwb_adr = 32'h0000_0200; iwb_cyc = 1'b1; iwb_stb = 1'b1;
        dwb_adr = 32'h0000_2000; dwb_dat = 32'h55; dwb_we = 1'b1; dwb_sel = 4'h1;
        dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick(); smp();
        check("cont_grant", 32'(a_grant),   32'd2);
        check("cont_adr",   a_mwb_adr,      32'h0000_2000);
        check("cont_dat",   a_mwb_dat,      32'h55);
        check("cont_we",    32'(a_mwb_we),  32'd1);
        check("cont_sel",   32'(a_mwb_sel), 32'h1);
        check("cont_rr_grant", 32'(b_grant), 32'd2);
        mwb_ack = 1'b1;
        smp();
        check("cont_dack", 32'(a_dwb_ack), 32'd1);
        check("cont_iack", 32'(a_iwb_ack), 32'd0);
        tick();
        mwb_ack = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0; dwb_we = 1'b0;
        smp();
        check("cont_hold",  32'(a_grant),   32'd2);
        check("cont_cyc_pass", 32'(a_mwb_cyc), 32'd0);
        tick(); smp();
        check("handover_grant", 32'(a_grant), 32'd1);
        check("handover_adr",   a_mwb_adr,    32'h0000_0200);
        check("handover_dat",   a_mwb_dat,    32'd0);
        mwb_ack = 1'b1;
        smp();
        check("handover_iack", 32'(a_iwb_ack), 32'd1);
        tick();
        mwb_ack = 1'b0; iwb_cyc = 1'b0; iwb_stb = 1'b0;
        tick();

        // Simultaneous ack and err: err wins. Then a late ack while idle is dropped.
        dwb_adr = 32'h0000_3000; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick();
        mwb_ack = 1'b1; mwb_err = 1'b1;
        smp();
        check("ackerr_err", 32'(a_dwb_err), 32'd1);
        check("ackerr_ack", 32'(a_dwb_ack), 32'd0);
        tick();
        mwb_ack = 1'b0; mwb_err = 1'b0; dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();
        mwb_ack = 1'b1;
        smp();
        check("late_ack_grant", 32'(a_grant),   32'd0);
        check("late_ack_d",     32'(a_dwb_ack), 32'd0);
        check("late_ack_i",     32'(a_iwb_ack), 32'd0);
        tick();
        mwb_ack = 1'b0;

        // Round-robin on b: both ports keep requesting, owner drops cyc after each beat.
        do_reset();
        iwb_adr = 32'h0000_0300; iwb_cyc = 1'b1; iwb_stb = 1'b1;
        dwb_adr = 32'h0000_0400; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick();
        exp_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            check($sformatf("rr_grant%0d", k), 32'(b_grant), exp_d ? 32'd2 : 32'd1);
            mwb_ack = 1'b1;
            smp();
            check($sformatf("rr_ack%0d", k), 32'(exp_d ? b_dwb_ack : b_iwb_ack), 32'd1);
            tick();
            mwb_ack = 1'b0;
            if (exp_d) begin dwb_cyc = 1'b0; dwb_stb = 1'b0; end
            else       begin iwb_cyc = 1'b0; iwb_stb = 1'b0; end
            tick();
            if (exp_d) begin dwb_cyc = 1'b1; dwb_stb = 1'b1; end
            else       begin iwb_cyc = 1'b1; iwb_stb = 1'b1; end
            exp_d = ~exp_d;
        end

        // Watchdog on a: four stalled strobe cycles, then a forced error cycle.
        do_reset();
        dwb_adr = 32'h0000_0500; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            smp();
            check($sformatf("wd_stb%0d", i), 32'(a_mwb_stb), 32'd1);
            check($sformatf("wd_quiet%0d", i), 32'({a_timeout, a_dwb_err}), 32'd0);
            tick();
        end
        smp();
        check("wd_timeout", 32'(a_timeout), 32'd1);
        check("wd_derr",    32'(a_dwb_err), 32'd1);
        check("wd_cyc",     32'(a_mwb_cyc), 32'd0);
        check("wd_stb",     32'(a_mwb_stb), 32'd0);
        tick(); smp();
        check("wd_idle",    32'(a_grant),   32'd0);
        check("wd_pulse",   32'(a_timeout), 32'd0);
        check("wd_err_off", 32'(a_dwb_err), 32'd0);
        dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();

        // Asynchronous reset in the middle of a data cycle.
        iwb_adr = 32'h0000_0600; iwb_cyc = 1'b1; iwb_stb = 1'b1;
        dwb_adr = 32'h0000_0700; dwb_cyc = 1'b1; dwb_stb = 1'b1;
        tick(); smp();
        check("ar_pre_grant", 32'(a_grant), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_cyc",   32'(a_mwb_cyc), 32'd0);
        check("ar_stb",   32'(a_mwb_stb), 32'd0);
        check("ar_grant", 32'(a_grant),   32'd0);
        dwb_cyc = 1'b0; dwb_stb = 1'b0;
        tick();
        rst_n = 1'b1;
        smp();
        check("ar_released_idle", 32'(a_grant), 32'd0);
        tick(); smp();
        check("ar_regrant", 32'(a_grant), 32'd1);
        check("ar_adr",     a_mwb_adr,    32'h0000_0600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
Two-master to one-slave Wishbone arbiter. It merges the core's instruction fetch bus (iwb) and data bus (dwb) onto a single shared memory/peripheral master port (mwb), for single-port SoC memory maps. It sits between the hierarchical RV32IM top and the system interconnect. Grant is held for the full bus cycle. A watchdog terminates hung slave transactions with an error.

Parameters:
DATA_PRIORITY, 1, 1 = data port wins simultaneous requests; 0 = round-robin between ports.
TIMEOUT_CYCLES, 255, wait cycles (stb high, no ack/err) before forced error; 0 disables the watchdog.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
iwb_adr_i  input  32  instruction fetch address
iwb_dat_o  output  32  fetch read data
iwb_cyc_i  input  1  fetch cycle
iwb_stb_i  input  1  fetch strobe
iwb_ack_o  output  1  fetch acknowledge
iwb_err_o  output  1  fetch error
dwb_adr_i  input  32  data address
dwb_dat_i  input  32  data write data
dwb_dat_o  output  32  data read data
dwb_we_i  input  1  data write enable
dwb_sel_i  input  4  data byte selects
dwb_cyc_i  input  1  data cycle
dwb_stb_i  input  1  data strobe
dwb_ack_o  output  1  data acknowledge
dwb_err_o  output  1  data error
mwb_adr_o  output  32  shared bus address
mwb_dat_o  output  32  shared bus write data
mwb_dat_i  input  32  shared bus read data
mwb_we_o  output  1  shared bus write enable
mwb_sel_o  output  4  shared bus byte selects
mwb_cyc_o  output  1  shared bus cycle
mwb_stb_o  output  1  shared bus strobe
mwb_ack_i  input  1  shared bus acknowledge
mwb_err_i  input  1  shared bus error
grant_o  output  2  current owner {data, instr}; one-hot or 0
timeout_o  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, grant_o = 0, timeout_o = 0, watchdog counter = 0.
  - last_grant = instruction, so the first round-robin tie goes to data.
  - All mwb_* outputs and all ack/err outputs are 0.
- States: IDLE, GNT_I, GNT_D. A request is cyc_i & stb_i.
- Arbitration is registered, so there is one cycle of latency from request to mwb_cyc_o. No combinational path exists from a request input to mwb_cyc_o.
- IDLE:
  - Only one port requesting: go to its GNT state.
  - Both requesting: DATA_PRIORITY=1 selects GNT_D. DATA_PRIORITY=0 selects the port opposite last_grant.
  - No request: stay in IDLE; mwb_cyc/stb/we = 0, adr/dat/sel = 0.
- GNT_I:
  - mwb_adr_o = iwb_adr_i, mwb_cyc_o = iwb_cyc_i, mwb_stb_o = iwb_stb_i.
  - mwb_we_o = 0, mwb_sel_o = 4'hF, mwb_dat_o = 0.
- GNT_D: mwb_* are passed straight through from dwb_*.
- Response routing:
  - mwb_ack_i and mwb_err_i go only to the granted port's ack_o/err_o. The non-granted port sees 0.
  - iwb_dat_o and dwb_dat_o both equal mwb_dat_i at all times.
- Ownership and release:
  - Ownership persists across multiple stb beats while the owner's cyc_i stays high. There is no preemption.
  - Release occurs when the owner's cyc_i is low at a clock edge. On that edge last_grant is updated to the owner.
  - Handover: if the other port is requesting at release, go directly to its GNT state (no IDLE bubble). Otherwise go to IDLE.
  - Release and a re-request by the same port on the same edge: the other port wins if it is requesting, otherwise the same port is re-granted.
- Watchdog (TIMEOUT_CYCLES ≠ 0):
  - The counter increments each cycle in a GNT state with mwb_stb_o=1 and mwb_ack_i=0 and mwb_err_i=0.
  - It clears on ack, on err, and on any state change.
  - When the counter reaches TIMEOUT_CYCLES, that cycle does all of the following: drives err_o=1 to the owner, forces mwb_cyc_o=mwb_stb_o=0, pulses timeout_o, clears the counter, and goes to IDLE (normal arbitration follows).
  - Counter width is ceil(log2(TIMEOUT_CYCLES+1)).
- Slave ack and err in the same cycle: err wins, and ack_o is suppressed.
- A late mwb_ack_i arriving in IDLE is discarded (no ack_o).

Test Plan:
- Reset/idle: hold rst_n=0, drive requests -> all outputs 0. Release, no requests -> grant_o=0, mwb_cyc_o=0.
- Single fetch: iwb request to 0x0000_0100, slave acks 2 cycles later with 0xDEADBEEF -> grant_o=01 one cycle after the request; mwb_sel_o=F, we=0; iwb_ack_o and iwb_dat_o=0xDEADBEEF; dwb_ack_o stays 0.
- Contention, DATA_PRIORITY=1: both ports request the same cycle, dwb write 0x55 to 0x2000 sel=0001 -> GNT_D first. Drop dwb_cyc -> handover to GNT_I on the next edge with no IDLE cycle.
- Round-robin, DATA_PRIORITY=0: both ports request continuously, one beat per cycle -> grant order D, I, D, I.
- Watchdog, TIMEOUT_CYCLES=4: dwb request, slave never acks -> mwb_stb high 4 cycles; then dwb_err_o=1 and timeout_o=1 for 1 cycle, mwb_cyc_o=0, state returns to IDLE.
- Async reset mid-burst: rst_n low while GNT_D with stb high -> mwb_cyc_o falls without waiting for clk. After release, a pending iwb request is granted normally.
